shift_seq194: RTL
=================

SHIFT_SEQ194 -- requirements
Module: shift_seq194

Interface
REQ-001 SHALL have parameter DEPTH, default 2, command FIFO entries (power of two, 2..8).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port CR  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  FIFO not full; a command is accepted when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-006 SHALL have port cmd_op  in  2  00 HOLD, 01 SHR, 10 SHL, 11 LOAD.
REQ-007 SHALL have port cmd_data  in  4  LOAD: parallel word {A,B,C,D}; SHR/SHL: bit[0] is the serial fill bit.
REQ-008 SHALL have port cmd_len  in  3  cycles to apply the op; 0 means 8.
REQ-009 SHALL have ports S1,S0  out  1 each  mode to the 74LS194 stage.
REQ-010 SHALL have ports A,B,C,D  out  1 each  parallel data to the 74LS194 stage.
REQ-011 SHALL have ports SR,SL  out  1 each  serial right/left inputs to the 74LS194 stage.
REQ-012 SHALL have port busy  out  1  a command is executing.
REQ-013 SHALL have port done  out  1  one-cycle pulse in the last cycle of each command.

Function
REQ-014 SHALL implement FSM states IDLE and RUN only.
REQ-015 SHALL, in IDLE with FIFO non-empty, pop the head, load cnt with len (0 becomes 8), and enter RUN at the next edge.
REQ-016 SHALL, in RUN, drive {S1,S0} = cmd_op of the active command.
REQ-017 SHALL, in RUN, drive SR = fill for SHR and SL = fill for SHL; unused serial inputs and A-D SHALL be 0, except under LOAD.
REQ-018 SHALL, under LOAD, drive {A,B,C,D} = cmd_data.
REQ-019 SHALL register all outputs, so each mode value is stable for exactly cnt full clock periods and the downstream 74LS194 samples it on the cnt edges that follow.
REQ-020 SHALL decrement cnt every RUN cycle, and SHALL assert done in the cycle where cnt equals 1.
REQ-021 SHALL, at the end of a command, pop the next command with no gap if the FIFO is non-empty; otherwise it SHALL return to IDLE.
REQ-022 SHALL, in IDLE, drive {S1,S0} = 00 (hold) with all data and serial outputs 0.
REQ-023 SHALL set busy = 1 in RUN and busy = 0 in IDLE.
REQ-024 SHALL handle simultaneous push and pop when full: the pop frees the slot in the same edge, so cmd_ready is computed from the registered count only and stays 0 when full.
REQ-025 SHALL handle a push while empty in IDLE: the command starts one cycle after acceptance.
REQ-026 SHALL use wrap-around FIFO pointers modulo DEPTH with an occupancy counter 0..DEPTH.

Reset
REQ-027 SHALL, with CR = 1 at an edge, go to IDLE, empty the FIFO, set cnt = 0, S1 = S0 = 0, A-D = 0, SR = SL = 0, busy = 0, done = 0, and cmd_ready = 0 during reset and 1 in the cycle after.
REQ-028 SHALL, when CR is asserted mid-command, abort the command with no done pulse and discard all queued commands.

Structure
REQ-029 SHALL place the op encodings (HOLD/SHR/SHL/LOAD = 00/01/10/11, identical to the 74LS194 S1S0 modes) and the command record (op, data, len) in the shared package shift_pkg.
REQ-030 SHALL implement the FIFO as sub-module cmd_fifo, parameterised by DEPTH.

Verification
REQ-031 SHALL cover: LOAD 1000 with len 1, then SHR fill=1 with len 3, into a 74LS194 model -> Q progresses 1000, 1100, 1110, 1111; done pulses twice.
REQ-032 SHALL cover: SHL fill=0 with len 0 after LOAD 1111 -> 8 shift cycles, Q = 0000 after the 4th, busy high for 8 cycles.
REQ-033 SHALL cover: three back-to-back pushes with DEPTH=2 while busy -> cmd_ready drops to 0 after the 2nd accept, the 3rd waits, and the commands execute with no IDLE gap.
REQ-034 SHALL cover: HOLD with len 5 after LOAD 0001 -> Q stays 0001 for 5 cycles, S1S0 = 00.
REQ-035 SHALL cover: CR asserted during the 2nd cycle of SHR len 4 with one queued command -> next cycle outputs are all 0, busy = 0, no done, and the queued command is never executed.
REQ-036 SHALL cover: a push while empty at cycle t -> S1S0 reflects the op at t+2 and busy rises at t+2.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the 74LS194 command sequencer: op encodings, the queued
// command record and the decode from a command to the pins driven at the stage.
package shift_pkg;

   // Same encoding as the 74LS194 S1S0 mode pins, so an op drives the mode directly.
   typedef enum logic [1:0] {
      OpHold = 2'b00,
      OpShr  = 2'b01,
      OpShl  = 2'b10,
      OpLoad = 2'b11
   } op_e;

   typedef struct packed {
      op_e        op;
      logic [3:0] data;
      logic [2:0] len;
   } cmd_t;

   typedef struct packed {
      logic [1:0] mode;
      logic [3:0] par;
      logic       sr;
      logic       sl;
   } drive_t;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   localparam drive_t DriveIdle = '0;

   // A length field of zero encodes the longest run, eight cycles.
   function automatic logic [3:0] len_cycles(input logic [2:0] len);
      return (len == 3'd0) ? 4'd8 : {1'b0, len};
   endfunction

   function automatic drive_t drive_of(input cmd_t cmd);
      drive_t drv;
      drv      = DriveIdle;
      drv.mode = cmd.op;
      unique case (cmd.op)
         OpLoad:  drv.par = cmd.data;
         OpShr:   drv.sr  = cmd.data[0];
         OpShl:   drv.sl  = cmd.data[0];
         default: ;
      endcase
      return drv;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command queue for the shift sequencer: circular buffer with an occupancy counter.
module cmd_fifo
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  cmd_t wdata,
   input  logic pop,
   output cmd_t rdata,
   output logic empty,
   output logic full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/shift_seq194.sv
// Sequences queued mode/data commands onto a 74LS194 shift register; every pin is
// registered so each command's mode is held for exactly its cycle count.
module shift_seq194
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       CR,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_data,
   input  logic [2:0] cmd_len,
   output logic       S1,
   output logic       S0,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       SR,
   output logic       SL,
   output logic       busy,
   output logic       done
);

   logic [0:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   drive_t     drv_q, drv_d;
   logic       done_q, done_d;

   cmd_t new_cmd;
   cmd_t head;
   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;
   logic last_cycle;

   assign new_cmd = '{op: op_e'(cmd_op), data: cmd_data, len: cmd_len};

   // Ready looks only at the registered occupancy, so a full queue never accepts,
   // even on the edge that pops.
   assign cmd_ready  = ~CR & ~fifo_full;
   assign push       = cmd_valid & cmd_ready;
   assign last_cycle = (state_q == StRun) && (cnt_q == 4'd1);
   assign pop        = ~fifo_empty & ((state_q == StIdle) | last_cycle);

   cmd_fifo #(
      .DEPTH(DEPTH)
   ) u_cmd_fifo (
      .clk  (clk),
      .rst  (CR),
      .push (push),
      .wdata(new_cmd),
      .pop  (pop),
      .rdata(head),
      .empty(fifo_empty),
      .full (fifo_full)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drv_d   = drv_q;
      done_d  = 1'b0;
      if (pop) begin
         state_d = StRun;
         cnt_d   = len_cycles(head.len);
         drv_d   = drive_of(head);
         done_d  = (len_cycles(head.len) == 4'd1);
      end else if (last_cycle) begin
         state_d = StIdle;
         cnt_d   = '0;
         drv_d   = DriveIdle;
      end else if (state_q == StRun) begin
         cnt_d  = cnt_q - 4'd1;
         done_d = (cnt_q == 4'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (CR) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         drv_q   <= DriveIdle;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drv_q   <= drv_d;
         done_q  <= done_d;
      end
   end

   assign {S1, S0}     = drv_q.mode;
   assign {A, B, C, D} = drv_q.par;
   assign SR           = drv_q.sr;
   assign SL           = drv_q.sl;
   assign busy         = (state_q == StRun);
   assign done         = done_q;

endmodule
